mem_8x4: RTL and testbench
==========================

MEM_8X4 -- requirements
Module: mem_8x4

Interface
- REQ-001 The block SHALL have parameter DEPTH, default 8, meaning number of words; the design SHALL be verified at the default only.
- REQ-002 The block SHALL have parameter DATA_W, default 4, meaning bits per word.
- REQ-003 The block SHALL have parameter ADDR_W, default 3, meaning address width, equal to clog2(DEPTH).
- REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state SHALL update on its rising edge.
- REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning reset: synchronous, active-low.
- REQ-006 The block SHALL have port addr, input, ADDR_W bits, meaning the word address shared by read and write.
- REQ-007 The block SHALL have port data_in, input, DATA_W bits, meaning write data.
- REQ-008 The block SHALL have port wr, input, 1 bit, meaning write enable, active-high; 0 means read.
- REQ-009 The block SHALL have port data_out, output, DATA_W bits, meaning read data.

Function
- REQ-010 The block SHALL implement storage of DEPTH words of DATA_W bits, implemented as registers (no vendor RAM macro).
- REQ-011 On a rising clk edge with rst_n=1 and wr=1, mem[addr] SHALL take data_in; no other word SHALL change.
- REQ-012 On a rising clk edge with rst_n=1 and wr=0, storage SHALL hold its contents.
- REQ-013 data_out SHALL equal mem[addr] combinationally (zero-cycle read latency) at all times, including while wr=1.
- REQ-014 During a write cycle, data_out SHALL show the old contents of mem[addr] before the edge and the new contents after the edge, with no bypass of data_in.
- REQ-015 A write SHALL take effect with a latency of one edge; a read of the same address SHALL return the new value immediately after that edge.
- REQ-016 Every address 0..DEPTH-1 SHALL be valid; there is no out-of-range case at the defaults, and addresses SHALL NOT wrap beyond ADDR_W bits.
- REQ-017 Back-to-back writes on consecutive edges to any addresses SHALL each succeed, including repeated writes to one address; the last write SHALL win.
- REQ-018 If inputs are X or Z, the block SHALL be undefined; no X-protection logic is required.

Reset
- REQ-019 On a rising clk edge with rst_n=0, all DEPTH words SHALL be cleared to 0, regardless of wr, addr and data_in.
- REQ-020 While rst_n=0 after the first reset edge, data_out SHALL read 0 for every addr.
- REQ-021 Reset SHALL take priority over a simultaneous write; a write presented in a reset cycle SHALL be discarded.
- REQ-022 Deasserting rst_n SHALL take effect on the next edge, with no extra recovery cycles; a write in the first cycle with rst_n=1 SHALL succeed.

Verification
- REQ-023 Reset then read: hold rst_n=0 for 2 edges, then rst_n=1 and wr=0, and sweep addr 0..7 -> data_out=4'h0 at every address.
- REQ-024 Write then read-back: apply wr=1, addr=3, data_in=4'b1010 for one edge, then wr=0 with addr=3 held -> data_out=4'b1010 immediately after the edge and on all later cycles; addr=0 -> data_out=4'h0.
- REQ-025 Full sweep: write mem[i]=i+5 (mod 16) for i=0..7 on consecutive edges, then read back -> data_out equals 5,6,7,8,9,A,B,C.
- REQ-026 Overwrite and isolation: write addr 2=4'hF, then addr 2=4'h1, then addr 3=4'h6 -> addr 2 reads 4'h1, addr 3 reads 4'h6, and other words are unchanged.
- REQ-027 Reset priority: with memory loaded, assert rst_n=0 together with wr=1, addr=5, data_in=4'h9 for one edge -> all words read 0, including addr 5.
- REQ-028 Write-cycle read timing: hold addr=4 (old value 4'h2) and wr=1 with data_in=4'hC -> data_out=4'h2 before the edge and 4'hC after it.

Source files
------------

// File: rtl/mem_8x4.sv
// mem_8x4: register-file memory with zero-latency read and synchronous active-low clear
module mem_8x4 #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr,
   output logic [DATA_W-1:0] data_out
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         mem_d[i] = !rst_n ? '0 : (wr && addr == ADDR_W'(i)) ? data_in : mem_q[i];
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   // read straight from storage: new data appears only after the write edge
   assign data_out = mem_q[addr];
endmodule

// File: tb/tb_mem_8x4.sv
// tb_mem_8x4: randomized and directed scoreboard bench for mem_8x4
module tb_mem_8x4;
   logic       clk = 0, rst_n = 0, wr = 0;
   logic [2:0] addr = 0;
   logic [3:0] data_in = 0, data_out;
   int         errors = 0, checks = 0, phase = 0;
   typedef struct {logic [3:0] exp; logic [2:0] a; int ph;} item_t;
   item_t      sb[$];
   logic [3:0] model [8];
   mem_8x4 dut (.clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .wr(wr), .data_out(data_out));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      item_t it;
      if (sb.size() > 0) begin
         it = sb.pop_front();
         checks++;
         if (data_out !== it.exp) begin
            errors++;
            $display("FAIL read phase=%0d addr=%0d got=%h expected=%h", it.ph, it.a, data_out, it.exp);
         end
      end
   end
   // drive one cycle; expected read is the stored word before this cycle's edge
   task automatic step(input logic r, input logic w, input logic [2:0] a, input logic [3:0] d);
      @(posedge clk); #1;
      rst_n = r; wr = w; addr = a; data_in = d;
      if (!$isunknown(model[a])) sb.push_back('{model[a], a, phase});
      if (!r) foreach (model[i]) model[i] = 4'h0;
      else if (w) model[a] = d;
   endtask
   task automatic read_all();
      for (int i = 0; i < 8; i++) step(1, 0, 3'(i), 4'h0);
   endtask
   initial begin
      foreach (model[i]) model[i] = 4'bx;
      phase = 1;
      step(0, 0, 0, 0); step(0, 1, 6, 4'hF);
      read_all();
      phase = 2;
      step(1, 1, 3, 4'b1010);
      repeat (3) step(1, 0, 3, 0);
      step(1, 0, 0, 0);
      phase = 3;
      for (int i = 0; i < 8; i++) step(1, 1, 3'(i), 4'(i + 5));
      read_all();
      phase = 4;
      step(1, 1, 2, 4'hF); step(1, 1, 2, 4'h1); step(1, 1, 3, 4'h6);
      read_all();
      phase = 5;
      step(0, 1, 5, 4'h9);
      read_all();
      step(0, 0, 0, 0); step(1, 1, 1, 4'h7); step(1, 0, 1, 0);
      phase = 6;
      step(1, 1, 4, 4'h2); step(1, 1, 4, 4'hC); step(1, 0, 4, 0);
      phase = 7;
      repeat (400) step(($urandom % 20) != 0, 1'($urandom), 3'($urandom), 4'($urandom));
      read_all();
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
